// File: rtl/alu_exec_ctrl.sv
// Sequencing controller for the 8-bit ALU datapath: single-issue valid/ready
// instruction intake, 4x8 register file, registered ALU drive and flags.
module alu_exec_ctrl #(
  parameter int NREGS = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [15:0]  instr,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_z,
  input  logic         alu_n,
  input  logic         alu_c,
  input  logic         alu_v,
  output logic [3:0]   flags,
  output logic         done,
  output logic         err,
  input  logic [1:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_LDI = 4'h8,
    OP_NOP = 4'hF
  } opcode_t;

  state_t       state;
  state_t       state_next;
  logic [W-1:0] regs [NREGS];
  logic [1:0]   rd_q;
  logic         err_pend;

  logic [3:0]   opcode;
  logic [1:0]   rd;
  logic [1:0]   rs1;
  logic [1:0]   rs2;
  logic [W-1:0] imm;
  logic         is_alu;
  logic         accept;

  assign opcode = instr[15:12];
  assign rd     = instr[11:10];
  assign rs1    = instr[9:8];
  assign rs2    = instr[7:6];
  assign imm    = instr[W-1:0];
  assign is_alu = (opcode <= OP_NOT);
  assign accept = instr_valid && (state == ST_IDLE);

  assign dbg_data = regs[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = is_alu ? ST_EXEC : ST_DONE;
      end
      ST_EXEC: state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        err        = err_pend;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operands are captured at acceptance, so rd aliasing rs1/rs2 is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      flags    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rd_q     <= '0;
      err_pend <= 1'b0;
    end else begin
      if (accept) begin
        err_pend <= 1'b0;
        if (is_alu) begin
          alu_a  <= regs[rs1];
          alu_b  <= regs[rs2];
          alu_op <= opcode;
          rd_q   <= rd;
        end else if (opcode == OP_LDI) begin
          regs[rd] <= imm;
        end else if (opcode != OP_NOP) begin
          err_pend <= 1'b1;
        end
      end
      if (state == ST_EXEC) begin
        regs[rd_q] <= alu_result;
        flags      <= {alu_z, alu_n, alu_c, alu_v};
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: directed plan items plus randomized instructions
// checked against an arithmetic reference model of the controller + ALU.
`timescale 1ns/1ps
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [3:0]  alu_op, flags;
  logic        alu_z, alu_n, alu_c, alu_v;
  logic        done, err;
  logic [1:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;

  int vectors = 0;
  int miscompares = 0;

  alu_exec_ctrl #(.NREGS(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .flags(flags), .done(done), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  // Combinational ALU attached to the controller.
  logic [8:0] alu_t;
  always_comb begin
    alu_t = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op)
      4'h0: begin
        alu_t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c = alu_t[8];
        alu_v = (alu_a[7] == alu_b[7]) && (alu_t[7] != alu_a[7]);
      end
      4'h1: begin
        alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
        alu_c = alu_t[8];
        alu_v = (alu_a[7] != alu_b[7]) && (alu_t[7] != alu_a[7]);
      end
      4'h2: alu_t = {1'b0, alu_a & alu_b};
      4'h3: alu_t = {1'b0, alu_a | alu_b};
      4'h4: alu_t = {1'b0, alu_a ^ alu_b};
      4'h5: alu_t = {1'b0, ~alu_a};
      default: alu_t = '0;
    endcase
    alu_result = alu_t[7:0];
    alu_z = (alu_t[7:0] == 8'h00);
    alu_n = alu_t[7];
  end

  // Reference model state.
  int       m_regs [4];
  int       m_flags;
  int       m_a, m_b, m_op;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  function automatic void model_alu(input int op, input int a, input int b,
                                    output int res, output int f);
    int full, s, c, v;
    c = 0; v = 0; full = 0;
    case (op)
      0: begin full = a + b; c = (full > 255); s = sgn(a) + sgn(b); v = (s > 127 || s < -128); end
      1: begin full = a - b; c = (a >= b);     s = sgn(a) - sgn(b); v = (s > 127 || s < -128); end
      2: full = a & b;
      3: full = a | b;
      4: full = a ^ b;
      5: full = 255 - a;
      default: full = 0;
    endcase
    res = (full + 256) % 256;
    f = ((res == 0) ? 8 : 0) + ((res >= 128) ? 4 : 0) + c * 2 + v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_flags = 0; m_a = 0; m_b = 0; m_op = 0;
  endtask

  task automatic model_step(input logic [15:0] ins, output int lat, output int e);
    int op, rd, rs1, rs2, res, f;
    op = ins[15:12]; rd = ins[11:10]; rs1 = ins[9:8]; rs2 = ins[7:6];
    lat = 1; e = 0;
    if (op <= 5) begin
      m_a = m_regs[rs1]; m_b = m_regs[rs2]; m_op = op;
      model_alu(op, m_a, m_b, res, f);
      m_regs[rd] = res; m_flags = f; lat = 2;
    end else if (op == 8) begin
      m_regs[rd] = ins[7:0];
    end else if (op != 15) begin
      e = 1;
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int rs2);
    logic [3:0] o; logic [1:0] d, s1, s2;
    o = op[3:0]; d = rd[1:0]; s1 = rs1[1:0]; s2 = rs2[1:0];
    return {o, d, s1, s2, 6'b0};
  endfunction

  function automatic logic [15:0] mk_ldi(input int rd, input int imm);
    logic [1:0] d; logic [7:0] v;
    d = rd[1:0]; v = imm[7:0];
    return {4'h8, d, 2'b00, v};
  endfunction

  task automatic dbg_check(input string tag, input int addr, input int exp);
    dbg_addr = addr[1:0];
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 4; i++) dbg_check({tag, "_reg"}, i, m_regs[i]);
    check({tag, "_flags"}, flags, m_flags);
    check({tag, "_alu_a"}, alu_a, m_a);
    check({tag, "_alu_b"}, alu_b, m_b);
    check({tag, "_alu_op"}, alu_op, m_op);
  endtask

  // Issues one instruction and returns at the negedge where done should be high.
  task automatic send(input string tag, input logic [15:0] ins);
    int lat, e, got, waited;
    @(negedge clk);
    check({tag, "_done_idle"}, done, 0);
    instr = ins; instr_valid = 1'b1;
    waited = 0;
    while (instr_ready !== 1'b1 && waited < 10) begin
      @(negedge clk); waited++;
    end
    check({tag, "_ready"}, instr_ready, 1);
    model_step(ins, lat, e);
    @(posedge clk);
    #1;
    instr = 16'($urandom);  // garbage held valid while busy must be ignored
    got = 0;
    for (int i = 1; i <= 4 && got == 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = i;
    end
    instr_valid = 1'b0;
    check({tag, "_latency"}, got, lat);
    check({tag, "_err"}, err, e);
    check({tag, "_busy"}, instr_ready, 0);
    check_state(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check_state("reset");
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", instr_ready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=no_finish required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ops [4];
    int acc, dn, lat, e;
    model_reset();

    do_reset();

    // Overflowing add into the sign bit.
    send("ldi_r0", mk_ldi(0, 8'h7F));
    send("ldi_r1", mk_ldi(1, 8'h01));
    send("add_r2", mk(0, 2, 0, 1));
    dbg_check("add_r2_val", 2, 8'h80);
    check("add_r2_flags", flags, 4'b0101);

    send("sub_r3", mk(1, 3, 1, 1));
    dbg_check("sub_r3_val", 3, 8'h00);
    check("sub_r3_flags", flags, 4'b1010);
    send("ldi_ff", mk_ldi(0, 8'hFF));
    send("add_wrap", mk(0, 0, 0, 1));
    dbg_check("add_wrap_val", 0, 8'h00);
    check("add_wrap_flags", flags, 4'b1010);

    // Illegal opcode leaves state alone.
    send("ldi_55", mk_ldi(0, 8'h55));
    send("illegal", mk(9, 0, 0, 0));
    dbg_check("illegal_r0", 0, 8'h55);
    check("illegal_flags", flags, 4'b1010);

    // valid held high across four ALU ops.
    ops[0] = mk(0, 2, 0, 1);
    ops[1] = mk(1, 3, 2, 0);
    ops[2] = mk(4, 1, 3, 2);
    ops[3] = mk(0, 0, 1, 1);
    acc = 0; dn = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      check("b2b_ready", instr_ready, (c % 3 == 0) ? 1 : 0);
      check("b2b_done", done, (c % 3 == 2) ? 1 : 0);
      if (instr_ready === 1'b1) acc++;
      if (done === 1'b1) dn++;
      if (c % 3 == 0) begin
        instr = ops[c / 3];
        model_step(ops[c / 3], lat, e);
      end else begin
        instr = 16'($urandom);
      end
    end
    @(negedge clk);
    instr_valid = 1'b0;
    check("b2b_accepts", acc, 4);
    check("b2b_dones", dn, 4);
    check_state("b2b");

    // Logic ops, with NOT writing back over its own source.
    send("ldi_f0", mk_ldi(0, 8'hF0));
    send("ldi_3c", mk_ldi(1, 8'h3C));
    send("and", mk(2, 2, 0, 1));
    dbg_check("and_val", 2, 8'h30);
    check("and_cv", flags[1:0], 2'b00);
    send("or", mk(3, 3, 0, 1));
    dbg_check("or_val", 3, 8'hFC);
    check("or_cv", flags[1:0], 2'b00);
    send("xor", mk(4, 2, 0, 1));
    dbg_check("xor_val", 2, 8'hCC);
    check("xor_cv", flags[1:0], 2'b00);
    send("not_alias", mk(5, 0, 0, 1));
    dbg_check("not_val", 0, 8'h0F);
    check("not_cv", flags[1:0], 2'b00);

    // Reset during EXEC discards the instruction.
    @(negedge clk);
    instr = mk(0, 2, 0, 1); instr_valid = 1'b1;
    check("rst_exec_ready", instr_ready, 1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_exec_done", done, 0);
    @(negedge clk);
    check("rst_exec_done2", done, 0);
    check_state("rst_exec");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_exec_ready_after", instr_ready, 1);
    check("rst_exec_done3", done, 0);

    // Reset during DONE of an illegal instruction kills both pulses.
    send("ill_before_rst", mk(10, 1, 0, 0));
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_done_done", done, 0);
    check("rst_done_err", err, 0);
    check_state("rst_done");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_done_ready", instr_ready, 1);

    // Randomized instruction stream.
    for (int i = 0; i < 4; i++) send("rnd_seed", mk_ldi(i, $urandom_range(0, 255)));
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ins;
      int op;
      op = (i % 4 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 5);
      ins = 16'($urandom);
      ins[15:12] = op[3:0];
      send("rnd", ins);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
